// File: rtl/pic_ctrl_seq.sv
`default_nettype none
// ==========================================================================
// pic_ctrl_seq : PIC INT/INTA control sequencer, 8086 (2 INTA) / 8080 (3 INTA)
// Revision     : 1.0
// ==========================================================================
module pic_ctrl_seq #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inta_n,
  input  logic               int_req,
  input  logic [IDX_W-1:0]   int_idx,
  input  logic               mode_8086,
  input  logic               single_mode,
  input  logic               is_master,
  input  logic [NUM_IRQ-1:0] slave_mask,
  input  logic               cas_match,
  input  logic               auto_eoi,
  input  logic [4:0]         vector_base,
  input  logic [7:0]         vector_hi,
  input  logic               wr_busy,
  input  logic               rd_cmd,
  input  logic [1:0]         ocw3_rr,
  output logic               int_o,
  output logic               freeze,
  output logic               latch_prio,
  output logic [IDX_W-1:0]   isr_idx,
  output logic               eoi_pulse,
  output logic [7:0]         vec_out,
  output logic               vec_oe,
  output logic               cas_en,
  output logic [2:0]         cas_id,
  output logic               rd_isr,
  output logic               rd_irr
);

  localparam logic [2:0]       c_idle     = 3'd0;
  localparam logic [2:0]       c_req      = 3'd1;
  localparam logic [2:0]       c_ack1     = 3'd2;
  localparam logic [2:0]       c_ack2     = 3'd3;
  localparam logic [2:0]       c_ack3     = 3'd4;
  localparam logic [IDX_W-1:0] c_spur_idx = IDX_W'(NUM_IRQ - 1);
  localparam logic [7:0]       c_call_op  = 8'hCD;

  logic [2:0]             r_state, w_state_nxt;
  logic                   r_inta_d, r_rd_d, r_sel_isr, r_spur;
  logic                   w_fall, w_rise, w_rd_rise, w_gate, w_spur_now;
  logic [IDX_W-1:0]       w_first_idx;
  logic [(1<<IDX_W)-1:0]  w_mask_ext;
  logic [2:0]             w_isr3;
  logic                   w_slave_off, w_cas_first, w_cas_isr, w_drv_first, w_drv;
  logic                   w_int_nxt, w_freeze_nxt, w_latch_nxt, w_eoi_nxt, w_oe_nxt;
  logic                   w_cas_en_nxt, w_spur_nxt, w_sel_nxt, w_rd_isr_nxt, w_rd_irr_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [7:0]             w_vec_nxt;
  logic [2:0]             w_cas_id_nxt;

  assign w_fall      = r_inta_d & ~inta_n;
  assign w_rise      = ~r_inta_d & inta_n;
  assign w_rd_rise   = ~r_rd_d & rd_cmd;
  assign w_gate      = int_req & ~wr_busy & ~rd_cmd;
  // An acknowledge with no live request behind it is spurious.
  assign w_spur_now  = (r_state == c_idle) | ~int_req;
  assign w_first_idx = w_spur_now ? c_spur_idx : int_idx;

  always_comb begin
    w_mask_ext = '0;
    w_mask_ext[NUM_IRQ-1:0] = slave_mask;
  end

  always_comb begin
    w_isr3 = '0;
    w_isr3[IDX_W-1:0] = isr_idx;
  end

  assign w_slave_off = ~is_master & ~single_mode & ~cas_match;
  assign w_cas_first = is_master & ~single_mode & w_mask_ext[w_first_idx];
  assign w_cas_isr   = is_master & ~single_mode & w_mask_ext[isr_idx];
  assign w_drv_first = ~w_cas_first & ~w_slave_off;
  assign w_drv       = ~w_cas_isr & ~w_slave_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_idle;
      r_inta_d   <= 1'b1;
      r_rd_d     <= 1'b0;
      r_sel_isr  <= 1'b0;
      r_spur     <= 1'b0;
      int_o      <= 1'b0;
      freeze     <= 1'b0;
      latch_prio <= 1'b0;
      isr_idx    <= '0;
      eoi_pulse  <= 1'b0;
      vec_out    <= '0;
      vec_oe     <= 1'b0;
      cas_en     <= 1'b0;
      cas_id     <= '0;
      rd_isr     <= 1'b0;
      rd_irr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inta_d   <= inta_n;
      r_rd_d     <= rd_cmd;
      r_sel_isr  <= w_sel_nxt;
      r_spur     <= w_spur_nxt;
      int_o      <= w_int_nxt;
      freeze     <= w_freeze_nxt;
      latch_prio <= w_latch_nxt;
      isr_idx    <= w_idx_nxt;
      eoi_pulse  <= w_eoi_nxt;
      vec_out    <= w_vec_nxt;
      vec_oe     <= w_oe_nxt;
      cas_en     <= w_cas_en_nxt;
      cas_id     <= w_cas_id_nxt;
      rd_isr     <= w_rd_isr_nxt;
      rd_irr     <= w_rd_irr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (w_fall)      w_state_nxt = c_ack1;
        else if (w_gate) w_state_nxt = c_req;
      end
      c_req: begin
        if (w_fall)        w_state_nxt = c_ack1;
        else if (!int_req) w_state_nxt = c_idle;
      end
      c_ack1: if (w_fall) w_state_nxt = c_ack2;
      c_ack2: if (w_rise) w_state_nxt = mode_8086 ? c_idle : c_ack3;
      c_ack3: if (w_rise) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_int_nxt    = int_o;
    w_freeze_nxt = freeze;
    w_latch_nxt  = 1'b0;
    w_idx_nxt    = isr_idx;
    w_eoi_nxt    = 1'b0;
    w_vec_nxt    = vec_out;
    w_oe_nxt     = vec_oe;
    w_cas_en_nxt = cas_en;
    w_cas_id_nxt = cas_id;
    w_spur_nxt   = r_spur;
    case (r_state)
      c_idle, c_req: begin
        if (w_fall) begin
          w_int_nxt    = 1'b0;
          w_freeze_nxt = 1'b1;
          w_latch_nxt  = ~w_spur_now;
          w_idx_nxt    = w_first_idx;
          w_spur_nxt   = w_spur_now;
          if (!mode_8086) begin
            w_vec_nxt = c_call_op;
            w_oe_nxt  = w_drv_first;
          end
        end else if (r_state == c_idle) begin
          if (w_gate) w_int_nxt = 1'b1;
        end else if (!int_req) begin
          w_int_nxt = 1'b0;
        end
      end
      c_ack1: begin
        if (w_fall) begin
          if (w_cas_isr) begin
            w_cas_en_nxt = 1'b1;
            w_cas_id_nxt = w_isr3;
          end
          w_vec_nxt = mode_8086 ? {vector_base, w_isr3} : {vector_base[4:2], w_isr3, 2'b00};
          w_oe_nxt  = w_drv;
        end else if (w_rise) begin
          w_oe_nxt = 1'b0;
        end
      end
      c_ack2: begin
        if (w_rise) begin
          w_oe_nxt = 1'b0;
          if (mode_8086) begin
            w_cas_en_nxt = 1'b0;
            w_freeze_nxt = 1'b0;
            w_eoi_nxt    = auto_eoi & ~r_spur;
          end
        end
      end
      c_ack3: begin
        if (w_fall) begin
          w_vec_nxt = vector_hi;
          w_oe_nxt  = w_drv;
        end else if (w_rise) begin
          w_oe_nxt     = 1'b0;
          w_cas_en_nxt = 1'b0;
          w_freeze_nxt = 1'b0;
          w_eoi_nxt    = auto_eoi & ~r_spur;
        end
      end
      default: ;
    endcase

    // Read select updates on the strobe's rising edge; the data bus wins over status reads.
    w_sel_nxt = r_sel_isr;
    if (w_rd_rise && ocw3_rr[1]) w_sel_nxt = ocw3_rr[0];
    w_rd_isr_nxt = w_sel_nxt & rd_cmd & ~w_oe_nxt;
    w_rd_irr_nxt = ~w_sel_nxt & rd_cmd & ~w_oe_nxt;
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_ctrl_seq.sv
`default_nettype none
// ==========================================================================
// tb_pic_ctrl_seq : self-checking bench for pic_ctrl_seq
// Revision        : 1.0
// ==========================================================================
module tb_pic_ctrl_seq;
  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  logic clk = 1'b0;
  logic reset, inta_n, int_req, mode_8086, single_mode, is_master, cas_match, auto_eoi;
  logic wr_busy, rd_cmd;
  logic [IDX_W-1:0] int_idx;
  logic [NUM_IRQ-1:0] slave_mask;
  logic [4:0] vector_base;
  logic [7:0] vector_hi;
  logic [1:0] ocw3_rr;
  logic int_o, freeze, latch_prio, eoi_pulse, vec_oe, cas_en, rd_isr, rd_irr;
  logic [IDX_W-1:0] isr_idx;
  logic [7:0] vec_out;
  logic [2:0] cas_id;

  pic_ctrl_seq #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .inta_n(inta_n), .int_req(int_req), .int_idx(int_idx),
    .mode_8086(mode_8086), .single_mode(single_mode), .is_master(is_master),
    .slave_mask(slave_mask), .cas_match(cas_match), .auto_eoi(auto_eoi),
    .vector_base(vector_base), .vector_hi(vector_hi), .wr_busy(wr_busy), .rd_cmd(rd_cmd),
    .ocw3_rr(ocw3_rr), .int_o(int_o), .freeze(freeze), .latch_prio(latch_prio),
    .isr_idx(isr_idx), .eoi_pulse(eoi_pulse), .vec_out(vec_out), .vec_oe(vec_oe),
    .cas_en(cas_en), .cas_id(cas_id), .rd_isr(rd_isr), .rd_irr(rd_irr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       int_o, freeze, latch_prio;
    logic [2:0] isr_idx;
    logic       eoi;
    logic [7:0] vec;
    logic       oe, cas_en;
    logic [2:0] cas_id;
    logic       rd_isr, rd_irr;
  } outs_t;

  // Reference model: tracks how many INTA pulses of the current acknowledge have been seen.
  outs_t m;
  logic  m_prev_inta, m_prev_rd, m_sel_isr, m_spur;
  int    m_pulses;

  // Observations gathered across a hand-written sequence.
  int         cnt_oe, cnt_lp, cnt_eoi;
  logic       seen_cas;
  logic [2:0] last_cas, eoi_idx;
  logic [7:0] last_vec;

  function automatic logic drives(input logic [2:0] k);
    return !(is_master && !single_mode && slave_mask[k]) && !(!is_master && !single_mode && !cas_match);
  endfunction

  task automatic model_step();
    logic fall, rise;
    logic [2:0] k;
    int needed;
    if (reset) begin
      m = '0; m_prev_inta = 1'b1; m_prev_rd = 1'b0; m_sel_isr = 1'b0; m_spur = 1'b0; m_pulses = 0;
      return;
    end
    fall = m_prev_inta && !inta_n;
    rise = !m_prev_inta && inta_n;
    needed = mode_8086 ? 2 : 3;
    m.latch_prio = 1'b0;
    m.eoi = 1'b0;
    if (m_pulses == 0) begin
      if (fall) begin
        m_spur = !(m.int_o && int_req);
        k = m_spur ? 3'(NUM_IRQ - 1) : int_idx;
        m.isr_idx = k; m.latch_prio = !m_spur; m.int_o = 1'b0; m.freeze = 1'b1; m_pulses = 1;
        if (!mode_8086) begin m.vec = 8'hCD; m.oe = drives(k); end
      end else if (m.int_o) begin
        if (!int_req) m.int_o = 1'b0;
      end else if (int_req && !wr_busy && !rd_cmd) begin
        m.int_o = 1'b1;
      end
    end else if (fall) begin
      m_pulses++;
      if (m_pulses == 2) begin
        if (is_master && !single_mode && slave_mask[m.isr_idx]) begin
          m.cas_en = 1'b1; m.cas_id = m.isr_idx;
        end
        m.vec = mode_8086 ? {vector_base, m.isr_idx} : {vector_base[4:2], m.isr_idx, 2'b00};
      end else begin
        m.vec = vector_hi;
      end
      m.oe = drives(m.isr_idx);
    end else if (rise) begin
      m.oe = 1'b0;
      if (m_pulses >= needed) begin
        m.cas_en = 1'b0; m.freeze = 1'b0; m.eoi = auto_eoi && !m_spur; m_pulses = 0;
      end
    end
    if (!m_prev_rd && rd_cmd) begin
      if (ocw3_rr == 2'b10) m_sel_isr = 1'b0;
      else if (ocw3_rr == 2'b11) m_sel_isr = 1'b1;
    end
    m.rd_isr = m_sel_isr && rd_cmd && !m.oe;
    m.rd_irr = !m_sel_isr && rd_cmd && !m.oe;
    m_prev_inta = inta_n;
    m_prev_rd = rd_cmd;
  endtask

  function automatic outs_t dut_outs();
    return {int_o, freeze, latch_prio, isr_idx, eoi_pulse, vec_out, vec_oe, cas_en, cas_id, rd_isr, rd_irr};
  endfunction

  task automatic tick();
    outs_t a;
    model_step();
    @(posedge clk);
    #1;
    a = dut_outs();
    n_tests++;
    if (a !== m) begin
      n_fail++;
      $display("FAIL model t=%0t: actual=%h required=%h", $time, a, m);
    end
    if (vec_oe) begin cnt_oe++; last_vec = vec_out; end
    if (latch_prio) cnt_lp++;
    if (eoi_pulse) begin cnt_eoi++; eoi_idx = isr_idx; end
    if (cas_en) begin seen_cas = 1'b1; last_cas = cas_id; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_obs();
    cnt_oe = 0; cnt_lp = 0; cnt_eoi = 0; seen_cas = 1'b0;
    last_cas = '0; eoi_idx = '0; last_vec = '0;
  endtask

  task automatic cfg(input logic md, input logic sngl, input logic mst, input logic [7:0] mask,
                     input logic cm, input logic aeoi, input logic [4:0] base);
    mode_8086 = md; single_mode = sngl; is_master = mst; slave_mask = mask;
    cas_match = cm; auto_eoi = aeoi; vector_base = base;
  endtask

  task automatic run_seq(input logic req, input logic [2:0] idx, input int npulses);
    clr_obs();
    int_req = req; int_idx = idx; inta_n = 1'b1;
    tick(); tick();
    for (int p = 0; p < npulses; p++) begin
      inta_n = 1'b0; tick(); tick();
      inta_n = 1'b1; tick(); tick();
    end
    int_req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       mode;
    logic [4:0] base;
    logic       req;
    logic [2:0] idx;
    logic       inta;
    logic       e_int, e_frz, e_lp, e_oe;
    logic [7:0] e_vec;
    logic [2:0] e_isr;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[2]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd3};
    tbl[3]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[4]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[5]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 3'd3};
    tbl[6]  = '{1'b1, 5'h08, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 3'd3};
    tbl[7]  = '{1'b1, 5'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h43, 3'd3};
    tbl[8]  = '{1'b1, 5'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h43, 3'd3};
    tbl[9]  = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 3'd3};
    tbl[10] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hCD, 3'd2};
    tbl[11] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCD, 3'd2};
    tbl[12] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE8, 3'd2};
    tbl[13] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE8, 3'd2};
    tbl[14] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 3'd2};
    tbl[15] = '{1'b0, 5'h1C, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd2};
    tbl[16] = '{1'b0, 5'h1C, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd2};

    reset = 1'b1; inta_n = 1'b1; int_req = 1'b0; int_idx = '0; wr_busy = 1'b0; rd_cmd = 1'b0;
    ocw3_rr = 2'b00; vector_hi = 8'hA5;
    cfg(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 5'h08);
    clr_obs();
    tick(); tick();
    chk("reset_outputs", 32'(dut_outs()), 32'd0);
    reset = 1'b0;
    tick();

    // Directed table: 8086 two-pulse then 8080 three-pulse acknowledge.
    for (int i = 0; i < 17; i++) begin
      mode_8086 = tbl[i].mode; vector_base = tbl[i].base;
      int_req = tbl[i].req; int_idx = tbl[i].idx; inta_n = tbl[i].inta;
      tick();
      chk($sformatf("tbl%0d_int_o", i), 32'(int_o), 32'(tbl[i].e_int));
      chk($sformatf("tbl%0d_freeze", i), 32'(freeze), 32'(tbl[i].e_frz));
      chk($sformatf("tbl%0d_latch", i), 32'(latch_prio), 32'(tbl[i].e_lp));
      chk($sformatf("tbl%0d_vec_oe", i), 32'(vec_oe), 32'(tbl[i].e_oe));
      chk($sformatf("tbl%0d_vec_out", i), 32'(vec_out), 32'(tbl[i].e_vec));
      chk($sformatf("tbl%0d_isr_idx", i), 32'(isr_idx), 32'(tbl[i].e_isr));
    end

    // Cascaded master with slave on channel 2.
    cfg(1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 5'h08);
    run_seq(1'b1, 3'd2, 2);
    chk("cas_master_cas_en", 32'(seen_cas), 32'd1);
    chk("cas_master_cas_id", 32'(last_cas), 32'd2);
    chk("cas_master_no_oe", 32'(cnt_oe), 32'd0);
    // Slave whose cascade ID does not match.
    cfg(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h08);
    run_seq(1'b1, 3'd2, 2);
    chk("cas_slave_no_oe", 32'(cnt_oe), 32'd0);
    chk("cas_slave_no_cas_en", 32'(seen_cas), 32'd0);

    // Auto-EOI on and off.
    cfg(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 5'h08);
    run_seq(1'b1, 3'd6, 2);
    chk("aeoi_pulse_count", 32'(cnt_eoi), 32'd1);
    chk("aeoi_pulse_idx", 32'(eoi_idx), 32'd6);
    chk("aeoi_latch_count", 32'(cnt_lp), 32'd1);
    auto_eoi = 1'b0;
    run_seq(1'b1, 3'd6, 2);
    chk("no_aeoi_pulse", 32'(cnt_eoi), 32'd0);

    // Request withdrawn while INT is pending.
    clr_obs();
    int_req = 1'b1; int_idx = 3'd4; tick();
    chk("req_int_up", 32'(int_o), 32'd1);
    int_req = 1'b0; tick();
    chk("req_drop_int_down", 32'(int_o), 32'd0);
    chk("req_drop_no_latch", 32'(cnt_lp), 32'd0);

    // Spurious acknowledge from IDLE, auto-EOI enabled but suppressed.
    auto_eoi = 1'b1;
    run_seq(1'b0, 3'd1, 2);
    chk("spur_vec", 32'(last_vec), 32'h47);
    chk("spur_isr_idx", 32'(isr_idx), 32'd7);
    chk("spur_no_latch", 32'(cnt_lp), 32'd0);
    chk("spur_no_eoi", 32'(cnt_eoi), 32'd0);
    auto_eoi = 1'b0;

    // Write cycle holds off INT.
    wr_busy = 1'b1; int_req = 1'b1; int_idx = 3'd1;
    tick(); tick(); tick();
    chk("wr_busy_blocks_int", 32'(int_o), 32'd0);
    wr_busy = 1'b0; tick();
    chk("wr_busy_release_int", 32'(int_o), 32'd1);
    int_req = 1'b0; tick();

    // Status read select.
    ocw3_rr = 2'b11; rd_cmd = 1'b1; tick();
    chk("rd_isr_sel", 32'({rd_isr, rd_irr}), 32'b10);
    rd_cmd = 1'b0; tick();
    chk("rd_idle", 32'({rd_isr, rd_irr}), 32'b00);
    ocw3_rr = 2'b01; rd_cmd = 1'b1; tick();
    chk("rd_keep_isr", 32'({rd_isr, rd_irr}), 32'b10);
    rd_cmd = 1'b0; tick();
    ocw3_rr = 2'b10; rd_cmd = 1'b1; tick();
    chk("rd_irr_sel", 32'({rd_isr, rd_irr}), 32'b01);
    rd_cmd = 1'b0; ocw3_rr = 2'b00; tick();

    // Asynchronous reset in the middle of an acknowledge.
    int_req = 1'b1; int_idx = 3'd5; tick(); tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    chk("pre_reset_freeze", 32'(freeze), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_clears", 32'(dut_outs()), 32'd0);
    int_req = 1'b0;
    tick();
    reset = 1'b0; tick();
    clr_obs();
    inta_n = 1'b0; tick();
    chk("post_reset_spur_latch", 32'(cnt_lp), 32'd0);
    chk("post_reset_spur_idx", 32'(isr_idx), 32'd7);
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick(); tick();

    // Randomized traffic against the model.
    for (int b = 0; b < 40; b++) begin
      cfg(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom));
      vector_hi = 8'($urandom);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(7) == 0) int_req = ~int_req;
        if ($urandom_range(3) == 0) int_idx = 3'($urandom);
        if ($urandom_range(3) == 0) inta_n = ~inta_n;
        wr_busy = ($urandom_range(5) == 0);
        if ($urandom_range(7) == 0) rd_cmd = ~rd_cmd;
        ocw3_rr = 2'($urandom);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
